// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller driving an external 1-cycle-latency RAM.
// Optional sticky overflow/underflow flags are enabled with FIFO_ERR_FLAGS_EN.
module fifo_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 6,
  parameter int AF_THRESH = 56,
  parameter int AE_THRESH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  output logic              ram_we_en,
  output logic [ADDR_W-1:0] ram_we_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_re_addr,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   AF_C     = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0]   AE_C     = (ADDR_W+1)'(AE_THRESH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_PART  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              almost_full_q, almost_full_d;
  logic              almost_empty_q, almost_empty_d;
  logic              pop_valid_q, pop_valid_d;
  logic              push_acc, pop_acc;

  always_comb begin
    push_acc       = push & ~rst & (state_q != S_FULL);
    pop_acc        = pop  & ~rst & (state_q != S_EMPTY);
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    state_d        = state_q;
    pop_valid_d    = pop_acc;

    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Transitions only fire on a net change in occupancy across a boundary.
    case (state_q)
      S_EMPTY: begin
        if (push_acc) state_d = S_PART;
        else          state_d = S_EMPTY;
      end
      S_PART: begin
        if (pop_acc && !push_acc && count_q == CNT_ONE)       state_d = S_EMPTY;
        else if (push_acc && !pop_acc && count_q == CNT_LAST) state_d = S_FULL;
        else                                                  state_d = S_PART;
      end
      S_FULL: begin
        if (pop_acc) state_d = S_PART;
        else         state_d = S_FULL;
      end
      default: state_d = S_EMPTY;
    endcase

    almost_full_d  = (count_d >= AF_C);
    almost_empty_d = (count_d <= AE_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_EMPTY;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      pop_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      pop_valid_q    <= pop_valid_d;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (push & (state_q == S_FULL));
    underflow_d = underflow_q | (pop  & (state_q == S_EMPTY));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  // A read pending across a reset must not surface while rst is held.
  assign pop_valid    = pop_valid_q & ~rst;
  assign pop_data     = ram_dout;
  assign full         = (state_q == S_FULL);
  assign empty        = (state_q == S_EMPTY);
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign count        = count_q;

  assign ram_we_en    = push_acc;
  assign ram_we_addr  = wr_ptr_q;
  assign ram_din      = push_data;
  assign ram_rd_en    = pop_acc;
  assign ram_re_addr  = rd_ptr_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl with a behavioural 1-cycle-latency RAM.
module tb_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic       push;
  logic [7:0] push_data;
  logic       pop;
  logic [7:0] pop_data;
  logic       pop_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [6:0] count;
  logic       overflow;
  logic       underflow;
  logic       ram_we_en;
  logic [5:0] ram_we_addr;
  logic [7:0] ram_din;
  logic       ram_rd_en;
  logic [5:0] ram_re_addr;
  logic [7:0] ram_dout;

  logic [7:0] mem [64];

  int         n_tests;
  int         n_fail;
  int         m_count;
  logic [5:0] m_wr;
  logic [5:0] m_rd;
  logic       m_pv;
  logic       m_ovf;
  logic       m_udf;
  logic [7:0] sb [$];

  fifo_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .push_data    (push_data),
    .pop          (pop),
    .pop_data     (pop_data),
    .pop_valid    (pop_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .ram_we_en    (ram_we_en),
    .ram_we_addr  (ram_we_addr),
    .ram_din      (ram_din),
    .ram_rd_en    (ram_rd_en),
    .ram_re_addr  (ram_re_addr),
    .ram_dout     (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we_en) mem[ram_we_addr] <= ram_din;
    if (ram_rd_en) ram_dout <= mem[ram_re_addr];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_status();
    check_val("count", 32'(count), 32'(m_count));
    check_val("full", 32'(full), 32'(m_count == 64));
    check_val("empty", 32'(empty), 32'(m_count == 0));
    check_val("almost_full", 32'(almost_full), 32'(m_count >= 56));
    check_val("almost_empty", 32'(almost_empty), 32'(m_count <= 8));
    check_val("overflow", 32'(overflow), 32'(m_ovf));
    check_val("underflow", 32'(underflow), 32'(m_udf));
    check_val("pop_valid", 32'(pop_valid), 32'(m_pv));
    if (pop_valid) begin
      if (sb.size() == 0) begin
        check_val("sb_nonempty", 32'(sb.size()), 32'd1);
      end else begin
        check_val("pop_data", 32'(pop_data), 32'(sb.pop_front()));
      end
    end
  endtask

  // One clock of stimulus: drive, compare at negedge, advance the model.
  task automatic step(input logic p, input logic [7:0] d, input logic q);
    logic ap;
    logic aq;
    push      = p;
    push_data = d;
    pop       = q;
    ap = p && (m_count != 64);
    aq = q && (m_count != 0);
    @(negedge clk);
    check_val("ram_we_en", 32'(ram_we_en), 32'(ap));
    check_val("ram_rd_en", 32'(ram_rd_en), 32'(aq));
    if (ap) begin
      check_val("ram_we_addr", 32'(ram_we_addr), 32'(m_wr));
      check_val("ram_din", 32'(ram_din), 32'(d));
    end
    if (aq) check_val("ram_re_addr", 32'(ram_re_addr), 32'(m_rd));
    check_status();
`ifdef FIFO_ERR_FLAGS_EN
    if (p && m_count == 64) m_ovf = 1'b1;
    if (q && m_count == 0)  m_udf = 1'b1;
`endif
    if (ap) begin
      sb.push_back(d);
      m_wr = m_wr + 6'd1;
    end
    if (aq) m_rd = m_rd + 6'd1;
    if (ap && !aq) m_count++;
    if (aq && !ap) m_count--;
    m_pv = aq;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    push = 1'b1;
    pop  = 1'b1;
    push_data = 8'h99;
    @(negedge clk);
    check_val("rst_we_en", 32'(ram_we_en), 32'd0);
    check_val("rst_rd_en", 32'(ram_rd_en), 32'd0);
    check_val("rst_pop_valid", 32'(pop_valid), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_val("rst_count", 32'(count), 32'd0);
    check_val("rst_empty", 32'(empty), 32'd1);
    check_val("rst_full", 32'(full), 32'd0);
    check_val("rst_almost_empty", 32'(almost_empty), 32'd1);
    check_val("rst_almost_full", 32'(almost_full), 32'd0);
    check_val("rst_overflow", 32'(overflow), 32'd0);
    check_val("rst_underflow", 32'(underflow), 32'd0);
    check_val("rst_pop_valid2", 32'(pop_valid), 32'd0);
    check_val("rst_we_en2", 32'(ram_we_en), 32'd0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    push = 1'b0;
    pop  = 1'b0;
    m_count = 0;
    m_wr    = 6'd0;
    m_rd    = 6'd0;
    m_pv    = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    sb.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got %0t expected < 2000000", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = 8'h00;
    ram_dout  = 8'h00;
    do_reset();

    // Basic ordering of three entries.
    step(1'b1, 8'hAA, 1'b0);
    step(1'b1, 8'hBB, 1'b0);
    step(1'b1, 8'hCC, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    check_val("req023_empty", 32'(empty), 32'd1);

    // Fill to 64, then one rejected push.
    do_reset();
    for (int i = 0; i < 64; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check_val("fill_count", 32'(count), 32'd64);
    check_val("fill_full", 32'(full), 32'd1);
    step(1'b1, 8'hEE, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // Push+pop while full, then 100 cycles of streaming through the wrap.
    step(1'b1, 8'h77, 1'b1);
    for (int i = 0; i < 100; i++) step(1'b1, 8'(i + 100), 1'b1);
    step(1'b0, 8'h00, 1'b0);
    check_val("stream_count", 32'(count), 32'd63);
    for (int i = 0; i < 63; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Underflow: pop empty, then push+pop together while empty.
    do_reset();
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h5A, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    check_val("udf_count", 32'(count), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Reset right after an accepted pop.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    do_reset();
    step(1'b1, 8'h11, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
